// File: rtl/ip4_axi_rd_arb.sv
// Shares the ip4 AXI master AR/R channels between NUM_REQ requesters; ARID carries the requester index in its top bits.
// Define IP4_AXI_RD_ARB_FIXPRI_EN for lowest-index-wins priority; otherwise round-robin.
module ip4_axi_rd_arb #(
    parameter int NUM_REQ      = 2,
    parameter int WID_AXI_ID   = 4,
    parameter int WID_AXI_ADDR = 32,
    parameter int WID_AXI_DATA = 64,
    parameter int WID_IDX      = $clog2(NUM_REQ),
    parameter int WID_SID      = WID_AXI_ID - WID_IDX,
    parameter int MAX_OUTS     = 4
) (
    input  logic                             aclk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               s_arvalid,
    output logic [NUM_REQ-1:0]               s_arready,
    input  logic [NUM_REQ*WID_SID-1:0]       s_arid,
    input  logic [NUM_REQ*WID_AXI_ADDR-1:0]  s_araddr,
    input  logic [NUM_REQ*4-1:0]             s_arlen,
    input  logic [NUM_REQ*3-1:0]             s_arsize,
    input  logic [NUM_REQ*2-1:0]             s_arburst,
    output logic [NUM_REQ-1:0]               s_rvalid,
    input  logic [NUM_REQ-1:0]               s_rready,
    output logic [WID_SID-1:0]               s_rid,
    output logic [WID_AXI_DATA-1:0]          s_rdata,
    output logic [1:0]                       s_rresp,
    output logic                             s_rlast,
    output logic                             m_arvalid,
    input  logic                             m_arready,
    output logic [WID_AXI_ID-1:0]            m_arid,
    output logic [WID_AXI_ADDR-1:0]          m_araddr,
    output logic [3:0]                       m_arlen,
    output logic [2:0]                       m_arsize,
    output logic [1:0]                       m_arburst,
    output logic [1:0]                       m_arlock,
    output logic [3:0]                       m_arcache,
    output logic [2:0]                       m_arprot,
    input  logic                             m_rvalid,
    output logic                             m_rready,
    input  logic [WID_AXI_ID-1:0]            m_rid,
    input  logic [WID_AXI_DATA-1:0]          m_rdata,
    input  logic [1:0]                       m_rresp,
    input  logic                             m_rlast,
    output logic [NUM_REQ*4-1:0]             outs_cnt,
    output logic                             err_rid
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [WID_IDX-1:0]      gnt_q, gnt_d;
    logic [WID_SID-1:0]      sid_q, sid_d;
    logic [WID_AXI_ADDR-1:0] addr_q, addr_d;
    logic [3:0]              len_q, len_d;
    logic [2:0]              size_q, size_d;
    logic [1:0]              burst_q, burst_d;
    logic [3:0]              cnt_q [NUM_REQ];
    logic [3:0]              cnt_d [NUM_REQ];
    logic                    err_rid_q, err_rid_d;

    logic [NUM_REQ-1:0]      elig;
    logic                    pick_vld;
    logic [WID_IDX-1:0]      pick;
    logic                    grant;
    logic [NUM_REQ-1:0]      inc, dec;
    logic [WID_IDX-1:0]      r_idx;
    logic                    r_idx_ok;
    logic                    r_sel_rdy;
    logic                    r_hs;

`ifndef IP4_AXI_RD_ARB_FIXPRI_EN
    logic [WID_IDX-1:0]      rr_ptr_q, rr_ptr_d;
    logic [WID_IDX:0]        cand;
`endif

    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = s_arvalid[i] && (cnt_q[i] < 4'(MAX_OUTS));
        end
    end

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
`ifdef IP4_AXI_RD_ARB_FIXPRI_EN
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_vld && elig[i]) begin
                pick_vld = 1'b1;
                pick     = WID_IDX'(i);
            end
        end
`else
        cand = '0;
        // Scan starting at rr_ptr, wrapping modulo NUM_REQ (which need not be a power of two).
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (WID_IDX+1)'(k);
            if (cand >= (WID_IDX+1)'(NUM_REQ)) begin
                cand = cand - (WID_IDX+1)'(NUM_REQ);
            end
            if (!pick_vld && elig[cand[WID_IDX-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[WID_IDX-1:0];
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sid_d     = sid_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        s_arready = '0;
        grant     = 1'b0;
`ifndef IP4_AXI_RD_ARB_FIXPRI_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        if (state_q == ST_IDLE) begin
            if (pick_vld) begin
                grant   = 1'b1;
                state_d = ST_BUSY;
                gnt_d   = pick;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (pick == WID_IDX'(i)) begin
                        s_arready[i] = 1'b1;
                        sid_d   = s_arid[i*WID_SID +: WID_SID];
                        addr_d  = s_araddr[i*WID_AXI_ADDR +: WID_AXI_ADDR];
                        len_d   = s_arlen[i*4 +: 4];
                        size_d  = s_arsize[i*3 +: 3];
                        burst_d = s_arburst[i*2 +: 2];
                    end
                end
`ifndef IP4_AXI_RD_ARB_FIXPRI_EN
                rr_ptr_d = (pick == WID_IDX'(NUM_REQ-1)) ? '0 : pick + 1'b1;
`endif
            end
        end else if (m_arready) begin
            state_d = ST_IDLE;
        end
    end

    // R routing: the index field of RID selects the requester; unknown indices are sunk.
    always_comb begin
        r_idx     = m_rid[WID_AXI_ID-1 -: WID_IDX];
        r_idx_ok  = ({1'b0, r_idx} < (WID_IDX+1)'(NUM_REQ));
        s_rvalid  = '0;
        r_sel_rdy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_idx == WID_IDX'(i)) begin
                s_rvalid[i] = m_rvalid;
                r_sel_rdy   = s_rready[i];
            end
        end
        m_rready  = r_idx_ok ? r_sel_rdy : 1'b1;
        r_hs      = m_rvalid && m_rready;
        err_rid_d = err_rid_q | (r_hs & ~r_idx_ok);
    end

    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            inc[i]   = grant && (pick == WID_IDX'(i));
            dec[i]   = r_hs && m_rlast && (r_idx == WID_IDX'(i));
            cnt_d[i] = cnt_q[i];
            if (inc[i] && !dec[i]) begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end else if (dec[i] && !inc[i] && (cnt_q[i] != 4'd0)) begin
                cnt_d[i] = cnt_q[i] - 4'd1;
            end
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sid_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_rid_q <= 1'b0;
`ifndef IP4_AXI_RD_ARB_FIXPRI_EN
            rr_ptr_q  <= '0;
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sid_q     <= sid_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            err_rid_q <= err_rid_d;
`ifndef IP4_AXI_RD_ARB_FIXPRI_EN
            rr_ptr_q  <= rr_ptr_d;
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        outs_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            outs_cnt[i*4 +: 4] = cnt_q[i];
        end
    end

    assign m_arvalid = (state_q == ST_BUSY);
    assign m_arid    = {gnt_q, sid_q};
    assign m_araddr  = addr_q;
    assign m_arlen   = len_q;
    assign m_arsize  = size_q;
    assign m_arburst = burst_q;
    assign m_arlock  = 2'b00;
    assign m_arcache = 4'b0000;
    assign m_arprot  = 3'b000;
    assign s_rid     = m_rid[WID_SID-1:0];
    assign s_rdata   = m_rdata;
    assign s_rresp   = m_rresp;
    assign s_rlast   = m_rlast;
    assign err_rid   = err_rid_q;

endmodule

// File: doc/ip4_axi_rd_arb.md
Name: ip4_axi_rd_arb

Overview:
- Shares the ip4 AXI master read channels (AR and R) between NUM_REQ internal requesters, e.g. instruction fetch and the DSE external interface path.
- Arbitrates AR requests and tags each accepted ARID with the requester index.
- Routes R beats back to the owning requester by ID.
- Enforces a per-requester limit on outstanding bursts.
- Sits between the internal requesters and the mst side of the ip4 AXI interface.

Parameters:
- NUM_REQ, 2: number of requesters; legal range 2..4.
- WID_AXI_ID, 4: master ARID/RID width.
- WID_AXI_ADDR, 32: address width.
- WID_AXI_DATA, 64: data width.
- WID_IDX, $clog2(NUM_REQ): requester-index field width. Occupies RID/ARID bits [WID_AXI_ID-1 -: WID_IDX].
- WID_SID, WID_AXI_ID-WID_IDX: width of the requester-local ID.
- MAX_OUTS, 4: maximum outstanding read bursts per requester; range 1..15.

Ports:
- aclk, in, 1: clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- s_arvalid, in, NUM_REQ: per-requester AR valid.
- s_arready, out, NUM_REQ: per-requester AR ready.
- s_arid, in, NUM_REQ*WID_SID: requester-local IDs, flattened; requester i occupies slice i.
- s_araddr, in, NUM_REQ*WID_AXI_ADDR: addresses, flattened.
- s_arlen, in, NUM_REQ*4: burst lengths, flattened.
- s_arsize, in, NUM_REQ*3: burst sizes, flattened.
- s_arburst, in, NUM_REQ*2: burst types, flattened.
- s_rvalid, out, NUM_REQ: routed R valid.
- s_rready, in, NUM_REQ: per-requester R ready.
- s_rid, out, WID_SID: local-ID bits of m_rid (broadcast to all requesters).
- s_rdata, out, WID_AXI_DATA: m_rdata (broadcast).
- s_rresp, out, 2: m_rresp (broadcast).
- s_rlast, out, 1: m_rlast (broadcast).
- m_arvalid, out, 1: master AR valid.
- m_arready, in, 1: master AR ready.
- m_arid, out, WID_AXI_ID: {grant index, local ID}.
- m_araddr, out, WID_AXI_ADDR: registered address.
- m_arlen, out, 4: registered burst length.
- m_arsize, out, 3: registered burst size.
- m_arburst, out, 2: registered burst type.
- m_arlock, out, 2: constant 0.
- m_arcache, out, 4: constant 0.
- m_arprot, out, 3: constant 0.
- m_rvalid, in, 1: master R valid.
- m_rready, out, 1: master R ready.
- m_rid, in, WID_AXI_ID: master R ID.
- m_rdata, in, WID_AXI_DATA: master R data.
- m_rresp, in, 2: master R response.
- m_rlast, in, 1: master R last.
- outs_cnt, out, NUM_REQ*4: per-requester outstanding-burst counters.
- err_rid, out, 1: sticky flag, set by an R beat carrying an out-of-range index.

Behaviour:
- Reset: all of the following are 0 and the FSM is in IDLE.
  - m_arvalid, s_arready, m_ar* registers, outs_cnt, err_rid.
  - Round-robin pointer rr_ptr, grant index gnt.
- AR FSM, two states:
  - IDLE:
    - Eligible requester i: s_arvalid[i]=1 and outs_cnt[i]<MAX_OUTS.
    - Pick the first eligible index at or after rr_ptr, wrapping modulo NUM_REQ.
    - If one is found: drive s_arready[gnt]=1 combinationally in that cycle and capture its fields into the m_ar* registers.
    - In the same cycle: increment outs_cnt[gnt], set rr_ptr <= (gnt+1) mod NUM_REQ, go to BUSY.
    - No eligible requester: stay in IDLE with all s_arready=0.
  - BUSY:
    - m_arvalid=1; m_ar* held stable.
    - On m_arready=1: clear m_arvalid and go to IDLE.
- AR throughput: one accepted burst per 2 cycles at most.
- AR latency: first m_arvalid appears 1 cycle after the s_ar handshake.
- s_arready is never asserted in BUSY.
- R path, purely combinational, zero latency:
  - idx = m_rid[WID_AXI_ID-1 -: WID_IDX].
  - Valid idx (idx<NUM_REQ): s_rvalid[idx]=m_rvalid, all other s_rvalid=0, m_rready=s_rready[idx].
  - Invalid idx (idx>=NUM_REQ): all s_rvalid=0, m_rready=1 (beat is sunk), err_rid is set on m_rvalid&m_rready. Only reset clears err_rid.
- Counters:
  - outs_cnt[i] decrements on m_rvalid&m_rready&m_rlast with idx==i.
  - Increment and decrement in the same cycle for the same i: counter unchanged.
  - Decrement when the count is 0 is a protocol error: the counter saturates at 0. Assertion is bench-only.
- A requester at MAX_OUTS is skipped by arbitration. rr_ptr advances only on a grant.
- Reset asserted mid-burst: everything is cleared immediately (asynchronous). Returning R beats are then routed by ID; counters do not go below 0.

Optional Feature:
- Macro: IP4_AXI_RD_ARB_FIXPRI_EN.
- Defined: fixed priority; the lowest eligible index wins. rr_ptr is removed.
- Undefined: round-robin as above.
- Counters, the MAX_OUTS limit and R routing are the same in both builds.

Test Plan:
- Single request: s_arvalid[1]=1, araddr=0x1000, arid=3 -> m_arvalid next cycle, m_arid=0xB (idx 1, sid 3), outs_cnt[1]=1. RID 0xB rlast beat -> s_rvalid[1]=1, outs_cnt[1]=0.
- Both requesters held valid, m_arready=1 -> grants alternate 0,1,0,1, one grant every 2 cycles. With FIXPRI_EN: requester 0 is granted every time.
- Hold m_arready=0 for 5 cycles in BUSY -> m_ar* stable, no s_arready, m_arvalid stays 1.
- Outstanding limit: issue 4 bursts on requester 0 with no R -> 5th request not granted while requester 1 is still granted. One rlast for requester 0 -> requester 0 granted next IDLE.
- Same cycle: grant to requester 0 and rlast for requester 0 with outs_cnt[0]=2 -> outs_cnt[0] stays 2.
- Invalid RID with NUM_REQ=3 (idx=3) -> m_rready=1, no s_rvalid, err_rid=1 and sticky. Assert rst_n=0 mid-BUSY -> all outputs 0 immediately.
